// File: rtl/user_seq_checker_pkg.sv
// user_seq_checker_pkg: shared memory-game types, widths and colour codes
package user_seq_checker_pkg;
  localparam int P_DATA = 4;
  typedef enum logic [2:0] {IDLE, WAIT_KEY, WAIT_REL, FETCH, CMP, DONE, FAIL} state_e;
  localparam logic [3:0] RED = 4'b0001;
  localparam logic [3:0] GRN = 4'b0010;
  localparam logic [3:0] BLU = 4'b0100;
  localparam logic [3:0] YEL = 4'b1000;
  function automatic logic is_colour(logic [3:0] k);
    return k inside {RED, GRN, BLU, YEL};
  endfunction
endpackage

// File: rtl/user_seq_checker_key_edge_capture.sv
// key_edge_capture: rising detect on any button and capture of the pressed value
module key_edge_capture (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_i,
  input  logic       en_i,
  output logic       press_o,
  output logic [3:0] cap_o
);
  logic [3:0] prev_q, cap_q, cap_d;
  // previous key tracks every cycle so a key held at turn start never counts
  assign press_o = |key_i && !(|prev_q);
  assign cap_d = (en_i && press_o) ? key_i : cap_q;
  assign cap_o = cap_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      cap_q <= '0;
    end else begin
      prev_q <= key_i;
      cap_q <= cap_d;
    end
  end
endmodule

// File: rtl/user_seq_checker.sv
// user_seq_checker: checks player presses against the sequence ROM, reports tc/err
module user_seq_checker #(
  parameter int P_DATA = user_seq_checker_pkg::P_DATA,
  parameter int P_TIMEOUT = 1000,
  parameter int P_TMR_W = 10
) (
  input  logic              clk,
  input  logic              R,
  input  logic              E,
  input  logic [P_DATA-1:0] data,
  input  logic [3:0]        key_in,
  input  logic [P_DATA-1:0] rom_data,
  output logic [P_DATA-1:0] SEQUSER,
  output logic              key_pulse,
  output logic              tc,
  output logic              err
);
  import user_seq_checker_pkg::*;
  localparam logic [P_TMR_W-1:0] TMO_LAST = P_TMR_W'(P_TIMEOUT - 1);
  state_e state_q, state_d;
  logic [P_DATA-1:0] seq_q, seq_d;
  logic [P_TMR_W-1:0] tmr_q, tmr_d;
  logic press, cap_en, match;
  logic [3:0] cap;
  assign cap_en = E && state_q == WAIT_KEY;
  key_edge_capture u_cap (
    .clk(clk),
    .rst(R),
    .key_i(key_in),
    .en_i(cap_en),
    .press_o(press),
    .cap_o(cap)
  );
  // multi-bit presses are never a valid colour, even if the ROM word matches
  assign match = P_DATA'(cap) == rom_data && is_colour(cap);
  always_comb begin
    state_d = state_q;
    seq_d = seq_q;
    tmr_d = '0;
    if (!E) begin
      state_d = IDLE;
      seq_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_KEY;
          seq_d = '0;
        end
        WAIT_KEY: begin
          state_d = press ? WAIT_REL : (tmr_q == TMO_LAST ? FAIL : WAIT_KEY);
          tmr_d = press ? '0 : tmr_q + 1'b1;
        end
        WAIT_REL: state_d = key_in == '0 ? FETCH : WAIT_REL;
        FETCH: state_d = CMP;
        CMP: begin
          state_d = !match ? FAIL : (seq_q == data ? DONE : WAIT_KEY);
          seq_d = (match && seq_q != data) ? seq_q + 1'b1 : seq_q;
        end
        default: state_d = state_q;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (R) begin
      state_q <= IDLE;
      seq_q <= '0;
      tmr_q <= '0;
    end else begin
      state_q <= state_d;
      seq_q <= seq_d;
      tmr_q <= tmr_d;
    end
  end
  assign SEQUSER = seq_q;
  assign key_pulse = cap_en && press;
  assign tc = state_q == DONE;
  assign err = state_q == FAIL;
endmodule

// File: tb/tb_user_seq_checker.sv
// tb_user_seq_checker: randomized turns, scoreboard of expected pulse/verdict events
module tb_user_seq_checker;
  logic clk = 0, R = 1, E = 0;
  logic [3:0] data = 0, key_in = 0, rom_data, SEQUSER;
  logic key_pulse, tc, err;
  logic [3:0] rom [16];
  int cyc = 0, checks = 0, errors = 0;
  typedef struct {int kind; int addr; int at;} ev_t;
  ev_t q[$];
  bit tc_q = 0, err_q = 0;

  user_seq_checker #(.P_TIMEOUT(8), .P_TMR_W(4)) dut (
    .clk(clk), .R(R), .E(E), .data(data), .key_in(key_in), .rom_data(rom_data),
    .SEQUSER(SEQUSER), .key_pulse(key_pulse), .tc(tc), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[SEQUSER];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // kind: 0 key_pulse, 1 tc rising, 2 err rising
  task automatic got(input int k);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d addr %0d cycle %0d, expected none", k, SEQUSER, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.addr != int'(SEQUSER) || e.at != cyc) begin
        errors++;
        $display("FAIL event: got kind %0d addr %0d cycle %0d, expected kind %0d addr %0d cycle %0d",
                 k, SEQUSER, cyc, e.kind, e.addr, e.at);
      end
    end
  endtask

  always @(negedge clk) begin
    if (tc || err) chk("tc_err_exclusive", {31'b0, tc && err}, 0);
    if (key_pulse === 1'b1) got(0);
    if (tc === 1'b1 && !tc_q) got(1);
    if (err === 1'b1 && !err_q) got(2);
    tc_q = (tc === 1'b1);
    err_q = (err === 1'b1);
  end

  // One player turn. WAIT_KEY is entered at edge m; a press driven after edge m+j
  // (j<8) is accepted; otherwise err rises at m+8. Release after edge n gives the
  // verdict at n+3 (FETCH, CMP, then DONE/FAIL); the next WAIT_KEY starts at n+3.
  task automatic turn(input int d, input bit rnd_rom, input int j0, input int bad_at,
                      input logic [3:0] bad_key, input bit pre_hold, input int abort_mode,
                      input int abort_k);
    int m, p, n, j, vcyc, vk;
    logic [3:0] k;
    bit ok, done;
    E = 0;
    key_in = 0;
    data = d[3:0];
    if (rnd_rom)
      for (int i = 0; i < 16; i++)
        rom[i] = ($urandom % 8 == 0) ? 4'($urandom_range(1, 15)) : 4'(1 << $urandom_range(0, 3));
    if (pre_hold) key_in = 4'b0001;
    step();
    step();
    E = 1;
    m = cyc + 1;
    done = 0;
    vcyc = cyc;
    vk = 0;
    if (pre_hold) begin
      repeat (3) step();
      key_in = 0;
    end
    for (int i = 0; i <= d && !done; i++) begin
      if (abort_mode != 0 && i == abort_k) begin
        while (cyc < m + 1) step();
        @(negedge clk);
        chk("seq_mid_turn", {28'b0, SEQUSER}, i);
        step();
        if (abort_mode == 1) R = 1;
        E = 0;
        step();
        R = 0;
        @(negedge clk);
        chk(abort_mode == 1 ? "reset_abort" : "enable_abort", {25'b0, key_pulse, tc, err, SEQUSER}, 0);
        step();
        return;
      end
      j = (i == 0 && j0 >= 0) ? j0 :
          ($urandom % 24 == 0) ? 8 + int'($urandom % 3) :
          int'($urandom_range((pre_hold && i == 0) ? 3 : 0, 7));
      p = m + j;
      if (j >= 8) begin
        q.push_back('{2, i, m + 8});
        vcyc = m + 8;
        vk = 2;
        done = 1;
      end else begin
        while (cyc < p) step();
        k = (i == bad_at) ? bad_key :
            (rnd_rom && $urandom % 8 == 0) ? 4'($urandom_range(1, 15)) : rom[i];
        key_in = k;
        q.push_back('{0, i, p});
        repeat ($urandom_range(1, 4)) begin
          step();
          if ($urandom % 3 == 0) key_in = k | 4'($urandom);
        end
        key_in = 0;
        n = cyc;
        ok = (k == rom[i]) && $countones(k) == 1;
        if (!ok || i == d) begin
          vk = ok ? 1 : 2;
          q.push_back('{vk, i, n + 3});
          vcyc = n + 3;
          done = 1;
        end else m = n + 3;
      end
    end
    while (cyc < vcyc + 1) step();
    repeat ($urandom_range(1, 3)) begin
      key_in = 4'($urandom_range(1, 15));
      repeat (2) step();
      key_in = 0;
      repeat (2) step();
    end
    @(negedge clk);
    chk("verdict_held", {30'b0, tc, err}, vk == 1 ? 2 : 1);
    step();
    E = 0;
    step();
    @(negedge clk);
    chk("cleared_on_e_low", {26'b0, tc, err, SEQUSER}, 0);
    step();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 4'b0001;
    R = 1;
    repeat (3) step();
    @(negedge clk);
    chk("reset_outputs", {25'b0, key_pulse, tc, err, SEQUSER}, 0);
    step();
    R = 0;
    step();
    rom[0] = 4'b0001; rom[1] = 4'b0100; rom[2] = 4'b1000;
    turn(2, 0, -1, -1, 4'b0, 0, 0, 0);
    turn(2, 0, -1, 1, 4'b0010, 0, 0, 0);
    rom[0] = 4'b0010;
    turn(0, 0, -1, -1, 4'b0, 0, 0, 0);
    rom[0] = 4'b0001;
    turn(1, 0, 8, -1, 4'b0, 0, 0, 0);
    turn(1, 0, 6, -1, 4'b0, 0, 0, 0);
    turn(2, 0, 5, -1, 4'b0, 1, 0, 0);
    turn(2, 0, -1, 0, 4'b0011, 0, 0, 0);
    turn(3, 0, -1, -1, 4'b0, 0, 1, 1);
    turn(3, 0, -1, -1, 4'b0, 0, 2, 1);
    for (int i = 0; i < 16; i++) rom[i] = 4'(1 << (i % 4));
    turn(15, 0, -1, -1, 4'b0, 0, 0, 0);
    for (int t = 0; t < 150; t++) begin
      int d, am, ak;
      d = int'($urandom_range(0, 15));
      am = (d > 0 && $urandom % 10 == 0) ? int'($urandom_range(1, 2)) : 0;
      ak = d > 0 ? int'($urandom_range(1, d)) : 0;
      turn(d, 1, -1, -1, 4'b0, 0, am, ak);
    end
    repeat (3) step();
    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/user_seq_checker.md
Name: user_seq_checker

Overview:
- Player-side counterpart of the FPGA sequence counter in the memory game.
- Each player button press is captured and the block issues its own ROM address.
- The captured press is compared against the ROM word, and the block reports round success (tc) or failure (err).
- Sits between the debounced button inputs, the sequence ROM read port and the top-level game FSM.

Parameters:
- P_DATA, 4, width of round limit, ROM address and ROM data.
- P_TIMEOUT, 1000, clk cycles allowed between presses before a timeout error.
- P_TMR_W, 10, timeout counter width; must satisfy 2^P_TMR_W > P_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- R  in  1  reset, synchronous, active-high.
- E  in  1  enable; high for the whole player turn, low aborts the turn.
- data  in  P_DATA  round limit; the turn holds data+1 entries (addresses 0..data).
- key_in  in  4  button levels, one bit per colour, already synchronized and debounced.
- rom_data  in  P_DATA  ROM word at SEQUSER; synchronous ROM, valid 1 cycle after the address changes.
- SEQUSER  out  P_DATA  ROM address of the expected entry.
- key_pulse  out  1  one-cycle strobe per accepted press (drives LED/sound).
- tc  out  1  turn completed correctly; held until R or E falls.
- err  out  1  mismatch or timeout; held until R or E falls.

Behaviour:
Reset:
- One clock and one reset, R synchronous active-high.
- While R=1 at a clk edge: state=IDLE, SEQUSER=0, key_pulse=0, tc=0, err=0, timer=0, captured key=0, previous key=0.
- R overrides everything, including mid-turn.

States: IDLE, WAIT_KEY, WAIT_REL, FETCH, CMP, DONE, FAIL.
- IDLE: SEQUSER=0, timer=0. If E=1, go to WAIT_KEY on the next cycle.
- WAIT_KEY:
  - Press = key_in != 0 while the previous-cycle key_in == 0 (rising detect on the OR of the bits).
  - On a press: capture key_in, key_pulse=1 for exactly that cycle, go to WAIT_REL.
  - Otherwise the timer increments. When timer == P_TIMEOUT-1 with no press, go to FAIL.
  - Timer clears on each accepted press.
- WAIT_REL:
  - Stay until key_in == 0, then go to FETCH.
  - Keys pressed during WAIT_REL are ignored (no second capture).
  - The timer does not run.
- FETCH: one wait cycle for ROM latency; SEQUSER is stable.
- CMP:
  - Captured key != rom_data → FAIL.
  - Captured key has more than one bit set → always a mismatch.
  - Match and SEQUSER == data → DONE.
  - Match and SEQUSER < data → SEQUSER+1, go to WAIT_KEY.
- DONE: tc=1. FAIL: err=1. Both are held while E=1; keys are ignored.
- E=0 in any non-IDLE state → IDLE next cycle: tc, err, SEQUSER and timer cleared; the partial turn is discarded.

Timing and corner cases:
- Latency: press edge → key_pulse same cycle as capture. Release → verdict 2 cycles later (FETCH, CMP).
- tc and err are never both 1.
- data = 0 → a single entry at address 0.
- data = 15 → 16 entries; SEQUSER never wraps past 15 because the end check precedes the increment.
- A key already held when E rises is not a press; it must be released first (previous-key register is updated in IDLE as well).
- All arithmetic is unsigned; the timer saturates logically by leaving WAIT_KEY at P_TIMEOUT-1.

Decomposition:
- Shared game package:
  - state encoding constants (IDLE..FAIL, 3 bits);
  - P_DATA;
  - one-hot colour codes (RED=0001, GRN=0010, BLU=0100, YEL=1000).
- One natural sub-module: key_edge_capture.
  - Holds the previous-key register and rising detect.
  - Outputs the press strobe and captured value, used by WAIT_KEY.
- The FSM, address counter and timer stay in user_seq_checker.

Test Plan:
- Reset, data=2, E=1; ROM 0:0001, 1:0100, 2:1000; press/release those in order → key_pulse ×3, SEQUSER 0→1→2, tc=1 two cycles after the last release, err=0.
- Same ROM; second press 0010 → err=1 after its release, tc=0, SEQUSER stays 1.
- data=0, ROM 0:0010, press 0010 → tc=1 after one entry; further presses give no key_pulse.
- P_TIMEOUT=8, E=1, no press → err=1 exactly 8 cycles after entering WAIT_KEY; a press at cycle 6 resets the timer with no err.
- Key 0001 held when E rises → no key_pulse until released and re-pressed; simultaneous 0011 press → err.
- Mid-turn (SEQUSER=1): R=1 for one cycle → all outputs 0 next cycle. Separately, E=0 mid-turn → IDLE with tc=err=0.
